// File: rtl/bsg_counter_pkg.sv
// Shared types for the bsg counter family.
package bsg_counter_pkg;

    typedef enum logic [0:0] {
        eIdle  = 1'b0,
        eCount = 1'b1
    } bsg_counter_down_state_e;

endpackage

// File: rtl/bsg_counter_dynamic_load_down_if.sv
// Load handshake for the dynamic-load down counter: start value over valid/ready.
interface bsg_counter_dynamic_load_down_if #(
    parameter int width_p = 16
);

    logic               load_v_i;
    logic [width_p-1:0] load_count_i;
    logic               load_ready_o;

    modport master (
        output load_v_i,
        output load_count_i,
        input  load_ready_o
    );

    modport slave (
        input  load_v_i,
        input  load_count_i,
        output load_ready_o
    );

endinterface

// File: rtl/bsg_dff_async_reset_en.sv
// Enable register with asynchronous active-high reset to zero.
module bsg_dff_async_reset_en #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_counter_dynamic_load_down.sv
// Loadable down counter with enable, abort, optional auto-reload and an expiry pulse.
module bsg_counter_dynamic_load_down
    import bsg_counter_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    bsg_counter_dynamic_load_down_if.slave        ld,
    input  logic                                  en_i,
    input  logic                                  reload_en_i,
    input  logic                                  abort_i,
    output logic [width_p-1:0]                    counter_o,
    output logic                                  busy_o,
    output logic                                  expired_o
);

    bsg_counter_down_state_e state_q;

    logic [width_p-1:0] counter_q, counter_d;
    logic [width_p-1:0] reload_q;
    logic               counter_en;
    logic               is_count;
    logic               load_fire;
    logic               le_one;
    logic               expire;

    assign is_count        = (state_q == eCount);
    assign ld.load_ready_o = ~is_count & ~reset_i;
    assign load_fire       = ld.load_v_i & ld.load_ready_o;

    // counter_r <= 1 without a full-width compare; a 1-bit counter is always <= 1
    if (width_p > 1) begin : g_le_wide
        assign le_one = ~|counter_q[width_p-1:1];
    end else begin : g_le_narrow
        assign le_one = 1'b1;
    end

    assign expire = is_count & en_i & ~abort_i & le_one;

    always_comb begin
        counter_d  = counter_q;
        counter_en = 1'b0;
        if (load_fire) begin
            counter_d  = ld.load_count_i;
            counter_en = 1'b1;
        end else if (is_count & abort_i) begin
            counter_d  = '0;
            counter_en = 1'b1;
        end else if (expire) begin
            counter_d  = reload_en_i ? reload_q : '0;
            counter_en = 1'b1;
        end else if (is_count & en_i) begin
            counter_d  = counter_q - width_p'(1);
            counter_en = 1'b1;
        end
    end

    bsg_dff_async_reset_en #(
        .width_p(width_p)
    ) counter_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (counter_en),
        .data_i (counter_d),
        .data_o (counter_q)
    );

    bsg_dff_async_reset_en #(
        .width_p(width_p)
    ) reload_reg (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (load_fire),
        .data_i (ld.load_count_i),
        .data_o (reload_q)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eIdle;
        end else begin
            case (state_q)
                eIdle: begin
                    if (load_fire) state_q <= eCount;
                end
                eCount: begin
                    if (abort_i | (expire & ~reload_en_i)) state_q <= eIdle;
                end
                default: state_q <= eIdle;
            endcase
        end
    end

    assign counter_o = counter_q;
    assign busy_o    = is_count;
    assign expired_o = expire;

endmodule

// File: tb/tb_bsg_counter_dynamic_load_down.sv
// Bench for bsg_counter_dynamic_load_down: per-cycle model compare plus directed literal checks.
module tb_bsg_counter_dynamic_load_down;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         en;
    logic         reload_en;
    logic         abort;
    logic [W-1:0] counter;
    logic         busy;
    logic         expired;

    int n_vec = 0;
    int n_err = 0;

    bsg_counter_dynamic_load_down_if #(.width_p(W)) ld_if ();

    bsg_counter_dynamic_load_down #(
        .width_p(W)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .ld         (ld_if),
        .en_i       (en),
        .reload_en_i(reload_en),
        .abort_i    (abort),
        .counter_o  (counter),
        .busy_o     (busy),
        .expired_o  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model tracks the loaded value and the enabled cycles elapsed in the current period.
    logic m_busy = 1'b0;
    int   m_n    = 0;
    int   m_k    = 0;

    always @(negedge clk) begin
        int  per;
        logic e_exp;
        if (reset) begin
            check("rst_counter", 32'(counter), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ready", 32'(ld_if.load_ready_o), 32'd0);
            check("rst_expired", 32'(expired), 32'd0);
            m_busy = 1'b0;
            m_n    = 0;
            m_k    = 0;
        end else begin
            per   = (m_n == 0) ? 1 : m_n;
            e_exp = m_busy && en && !abort && (m_k + 1 >= per);
            check("mdl_counter", 32'(counter), m_busy ? 32'(m_n - m_k) : 32'd0);
            check("mdl_busy", 32'(busy), 32'(m_busy));
            check("mdl_ready", 32'(ld_if.load_ready_o), 32'(!m_busy));
            check("mdl_expired", 32'(expired), 32'(e_exp));
            if (!m_busy) begin
                if (ld_if.load_v_i) begin
                    m_busy = 1'b1;
                    m_n    = int'(ld_if.load_count_i);
                    m_k    = 0;
                end
            end else if (abort) begin
                m_busy = 1'b0;
            end else if (e_exp) begin
                if (reload_en) m_k = 0;
                else           m_busy = 1'b0;
            end else if (en) begin
                m_k = m_k + 1;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic load(input logic [W-1:0] n);
        ld_if.load_v_i     = 1'b1;
        ld_if.load_count_i = n;
        nxt();
        ld_if.load_v_i     = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int last;
        reset              = 1'b0;
        en                 = 1'b0;
        reload_en          = 1'b0;
        abort              = 1'b0;
        ld_if.load_v_i     = 1'b0;
        ld_if.load_count_i = '0;
        #1 reset = 1'b1;

        smp();
        check("t0_counter", 32'(counter), 32'd0);
        check("t0_ready", 32'(ld_if.load_ready_o), 32'd0);
        nxt();
        reset = 1'b0;

        // basic N=3
        en = 1'b1;
        load(16'd3);
        smp(); check("t1_c3", 32'(counter), 32'd3); check("t1_e3", 32'(expired), 32'd0);
        nxt(); smp(); check("t1_c2", 32'(counter), 32'd2); check("t1_e2", 32'(expired), 32'd0);
        nxt(); smp(); check("t1_c1", 32'(counter), 32'd1); check("t1_e1", 32'(expired), 32'd1);
        nxt(); smp(); check("t1_cend", 32'(counter), 32'd0); check("t1_busy", 32'(busy), 32'd0);
        check("t1_ready", 32'(ld_if.load_ready_o), 32'd1);

        // enable gating: N=2, en 1,0,0,1
        nxt();
        load(16'd2);
        en = 1'b1; smp(); check("t2_c0", 32'(counter), 32'd2); check("t2_e0", 32'(expired), 32'd0);
        nxt(); en = 1'b0; smp(); check("t2_c1", 32'(counter), 32'd1); check("t2_e1", 32'(expired), 32'd0);
        nxt(); en = 1'b0; smp(); check("t2_c2", 32'(counter), 32'd1); check("t2_e2", 32'(expired), 32'd0);
        nxt(); en = 1'b1; smp(); check("t2_c3", 32'(counter), 32'd1); check("t2_e3", 32'(expired), 32'd1);
        nxt(); smp(); check("t2_busy", 32'(busy), 32'd0);

        // auto-reload N=4 over 12 enabled cycles
        nxt();
        load(16'd4);
        reload_en = 1'b1;
        en        = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            smp();
            check("t3_cnt", 32'(counter), 32'(4 - ((i - 1) % 4)));
            check("t3_exp", 32'(expired), 32'((i % 4) == 0));
            check("t3_busy", 32'(busy), 32'd1);
            nxt();
        end
        reload_en = 1'b0;
        repeat (4) nxt();
        smp(); check("t3_idle", 32'(busy), 32'd0);

        // N=0 and N=1
        nxt();
        load(16'd0);
        smp(); check("t4_n0_c", 32'(counter), 32'd0); check("t4_n0_e", 32'(expired), 32'd1);
        check("t4_n0_b", 32'(busy), 32'd1);
        nxt(); smp(); check("t4_n0_idle", 32'(busy), 32'd0);
        nxt();
        load(16'd1);
        smp(); check("t4_n1_c", 32'(counter), 32'd1); check("t4_n1_e", 32'(expired), 32'd1);
        nxt(); smp(); check("t4_n1_idle", 32'(busy), 32'd0); check("t4_n1_cend", 32'(counter), 32'd0);

        // N=0xFFFF: a single pulse on enabled cycle 65535
        nxt();
        load(16'hFFFF);
        pulses = 0;
        last   = 0;
        for (int i = 1; i <= 65536; i++) begin
            smp();
            if (expired) begin
                pulses++;
                last = i;
            end
            nxt();
        end
        check("t4_max_pulses", 32'(pulses), 32'd1);
        check("t4_max_when", 32'(last), 32'd65535);
        smp(); check("t4_max_cend", 32'(counter), 32'd0);

        // abort collides with expiry
        nxt();
        load(16'd1);
        abort = 1'b1;
        smp(); check("t5_e", 32'(expired), 32'd0);
        nxt(); abort = 1'b0;
        smp(); check("t5_busy", 32'(busy), 32'd0); check("t5_c", 32'(counter), 32'd0);

        // load held during COUNT is not taken until ready
        nxt();
        en = 1'b0;
        load(16'd5);
        ld_if.load_v_i     = 1'b1;
        ld_if.load_count_i = 16'd7;
        smp(); check("t5_rdy", 32'(ld_if.load_ready_o), 32'd0); check("t5_hold", 32'(counter), 32'd5);
        nxt(); smp(); check("t5_hold2", 32'(counter), 32'd5);
        nxt(); abort = 1'b1;
        nxt(); abort = 1'b0;
        smp(); check("t5_ab_c", 32'(counter), 32'd0); check("t5_ab_rdy", 32'(ld_if.load_ready_o), 32'd1);
        nxt(); ld_if.load_v_i = 1'b0;
        smp(); check("t5_new", 32'(counter), 32'd7); check("t5_newb", 32'(busy), 32'd1);
        nxt(); abort = 1'b1;
        nxt(); abort = 1'b0;

        // async reset mid-count
        en = 1'b1;
        load(16'd10);
        nxt(); nxt();
        smp(); check("t6_c8", 32'(counter), 32'd8);
        nxt();
        reset = 1'b1;
        #1;
        check("t6_rst_c", 32'(counter), 32'd0);
        check("t6_rst_b", 32'(busy), 32'd0);
        check("t6_rst_e", 32'(expired), 32'd0);
        nxt();
        reset = 1'b0;
        load(16'd2);
        smp(); check("t6_c2", 32'(counter), 32'd2);
        nxt(); smp(); check("t6_c1", 32'(counter), 32'd1); check("t6_e1", 32'(expired), 32'd1);
        nxt(); smp(); check("t6_idle", 32'(busy), 32'd0);
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
